carp_mem_initiator: RTL and testbench
=====================================

# carp_mem_initiator

Request-side master for one port of the CARP byte-write dual-port test memory. Accepts byte-addressed load/store requests from the core over a valid/ready handshake, converts them to word-addressed memory accesses with byte-lane strobes, and returns aligned, sign/zero-extended load data or a store acknowledge over a valid/ready response channel. One instance per memory port, between core and memory.

## Interface
Parameters:
- ADDR_WIDTH, 10, memory word-address width; request byte address is ADDR_WIDTH+2 bits
- NUM_COL, 4, byte lanes per word (fixed 4 for this block)
- COL_WIDTH, 8, bits per lane
- DATA_WIDTH, NUM_COL*COL_WIDTH, word width (32)

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_we_i  in  1  1=store, 0=load
- req_size_i  in  2  0=byte, 1=half, 2=word, 3=illegal
- req_unsigned_i  in  1  load zero-extends when 1, sign-extends when 0
- req_addr_i  in  ADDR_WIDTH+2  byte address
- req_wdata_i  in  DATA_WIDTH  store data, right-justified
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid&ready
- rsp_rdata_o  out  DATA_WIDTH  extended load data; 0 for stores and errors
- rsp_err_o  out  1  misaligned or illegal-size request
- mem_en_o  out  1  memory port enable
- mem_strobe_o  out  NUM_COL  byte-write strobes
- mem_addr_o  out  ADDR_WIDTH  word address = req_addr_i[ADDR_WIDTH+1:2]
- mem_data_o  out  DATA_WIDTH  store data replicated across lanes
- mem_data_i  in  DATA_WIDTH  memory read data, valid one cycle after mem_en_o

## Operation
- FSM states IDLE, WAIT, RESP. req_ready_o = (state==IDLE).
- IDLE: on req_valid_i: latch we, size, unsigned, addr[1:0], err; go WAIT. mem_en_o = accept & ~err, combinational in the accept cycle.
- WAIT: capture mem_data_i, extract, register rsp_rdata_o/rsp_err_o, assert rsp_valid_o; go RESP.
- RESP: hold rsp_* stable until rsp_ready_i; then deassert rsp_valid_o, go IDLE.
- Error: size 3; half with addr[0]=1; word with addr[1:0]!=0. No memory access (mem_en_o=0, strobes 0), rsp_err_o=1, rsp_rdata_o=0; same timing as a good request.
- Store strobes: byte 4'b0001<<addr[1:0]; half 4'b0011 (addr[1]=0) or 4'b1100; word 4'b1111. Load: strobes 0.
- mem_data_o: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
- Load extraction: lane = mem_data_i >> (8*addr[1:0]); byte/half extended per latched unsigned flag; word unchanged.
- Stores respond with rsp_rdata_o=0, rsp_err_o=0.
- mem_en_o=0 ⇒ mem_strobe_o, mem_addr_o, mem_data_o all driven 0.

## Timing
- Reset: state IDLE, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, req_ready_o=1, mem_en_o=0.
- Accept in cycle N ⇒ mem_en_o in N, rsp_valid_o from N+2; earliest next accept N+3 (rsp_ready_i=1 in N+2).
- Back-pressure: rsp_valid_o held with stable data indefinitely; req_ready_o=0 throughout.
- req_* inputs ignored outside IDLE; no combinational path from rsp_ready_i to req_ready_o.
- Reset mid-transaction: pending response discarded, no rsp_valid_o after reset release; a store issued in the accept cycle before reset is not rolled back.

## Test plan
- Word store 0xDEADBEEF to byte addr 0x010, then word load 0x010 -> strobe 4'b1111, mem_addr 0x004; load rsp_rdata 0xDEADBEEF at accept+2, err 0.
- Byte store 0x80 to 0x013 -> strobe 4'b1000, mem_data 0x80808080; signed byte load 0x013 -> 0xFFFFFF80; unsigned -> 0x00000080.
- Half load 0x012 over word 0x8001_1234, signed -> 0xFFFF8001; half load 0x010 unsigned -> 0x00001234.
- Misaligned half at 0x011, word at 0x012, size 3 -> mem_en_o never 1, rsp_err_o=1, rsp_rdata_o=0 at accept+2.
- Hold rsp_ready_i=0 for 5 cycles -> rsp_valid_o and data stable, req_ready_o=0; release -> req_ready_o=1 next cycle.
- Assert rst_ni low in WAIT -> outputs to reset values immediately; no response after release; next request completes normally.

Source files
------------

// File: rtl/carp_mem_initiator.sv
// carp_mem_initiator
//
// Request-side master for one port of the CARP byte-write dual-port memory.
// Takes byte-addressed load/store requests from the core, issues a single
// word-addressed memory access with byte-lane strobes, and returns an
// aligned, sign/zero-extended load result or a store acknowledge.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   req_valid_i/ready_o  request handshake (ready only while idle)
//   req_we_i             1 = store, 0 = load
//   req_size_i           0 = byte, 1 = half, 2 = word, 3 = illegal
//   req_unsigned_i       load zero-extends when 1, sign-extends when 0
//   req_addr_i           byte address (ADDR_WIDTH+2 bits)
//   req_wdata_i          right-justified store data
//   rsp_valid_o/ready_i  response handshake
//   rsp_rdata_o          extended load data, 0 for stores and errors
//   rsp_err_o            misaligned or illegal-size request
//   mem_en_o             memory enable, combinational in the accept cycle
//   mem_strobe_o         byte-write strobes
//   mem_addr_o           word address
//   mem_data_o           store data replicated across lanes
//   mem_data_i           memory read data, valid one cycle after mem_en_o
module carp_mem_initiator #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned NUM_COL    = 4,
    parameter int unsigned COL_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH = NUM_COL * COL_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_we_i,
    input  logic [1:0]              req_size_i,
    input  logic                    req_unsigned_i,
    input  logic [ADDR_WIDTH+1:0]   req_addr_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic                    mem_en_o,
    output logic [NUM_COL-1:0]      mem_strobe_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_data_o,
    input  logic [DATA_WIDTH-1:0]   mem_data_i
);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e                  r_state;
    state_e                  w_state_next;

    // Request attributes latched at accept, used when the read data returns.
    logic                    r_we;
    logic [1:0]              r_size;
    logic                    r_uns;
    logic [1:0]              r_off;
    logic                    r_err;

    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [DATA_WIDTH-1:0]   w_rdata_next;
    logic                    r_rsp_err;
    logic                    w_rsp_err_next;

    logic                    w_accept;
    logic                    w_err;
    logic                    w_mem_en;
    logic [NUM_COL-1:0]      w_strobe;
    logic [DATA_WIDTH-1:0]   w_wdata_rep;
    logic [DATA_WIDTH-1:0]   w_lane;
    logic [DATA_WIDTH-1:0]   w_load_data;

    // ------------------------------------------------------------------
    // Request decode (accept cycle)
    // ------------------------------------------------------------------
    assign w_accept = (r_state == StIdle) && req_valid_i;

    always_comb begin
        w_err = 1'b0;
        unique case (req_size_i)
            2'd0:    w_err = 1'b0;
            2'd1:    w_err = req_addr_i[0];
            2'd2:    w_err = (req_addr_i[1:0] != 2'b00);
            default: w_err = 1'b1;
        endcase
    end

    assign w_mem_en = w_accept && !w_err;

    always_comb begin
        w_strobe    = '0;
        w_wdata_rep = req_wdata_i;
        unique case (req_size_i)
            2'd0: begin
                w_strobe    = 4'b0001 << req_addr_i[1:0];
                w_wdata_rep = {NUM_COL{req_wdata_i[COL_WIDTH-1:0]}};
            end
            2'd1: begin
                w_strobe    = req_addr_i[1] ? 4'b1100 : 4'b0011;
                w_wdata_rep = {(NUM_COL / 2){req_wdata_i[2*COL_WIDTH-1:0]}};
            end
            default: begin
                w_strobe    = 4'b1111;
                w_wdata_rep = req_wdata_i;
            end
        endcase
        if (!req_we_i) begin
            w_strobe = '0;
        end
    end

    // Memory-side outputs are forced to zero whenever no access is issued.
    assign mem_en_o     = w_mem_en;
    assign mem_strobe_o = w_mem_en ? w_strobe : '0;
    assign mem_addr_o   = w_mem_en ? req_addr_i[ADDR_WIDTH+1:2] : '0;
    assign mem_data_o   = w_mem_en ? w_wdata_rep : '0;

    // ------------------------------------------------------------------
    // Load extraction (wait cycle). Lane offset is in bytes; lanes are 8 bits.
    // ------------------------------------------------------------------
    assign w_lane = mem_data_i >> {r_off, 3'b000};

    always_comb begin
        w_load_data = mem_data_i;
        unique case (r_size)
            2'd0: w_load_data = r_uns
                ? {{(DATA_WIDTH - COL_WIDTH){1'b0}}, w_lane[COL_WIDTH-1:0]}
                : {{(DATA_WIDTH - COL_WIDTH){w_lane[COL_WIDTH-1]}}, w_lane[COL_WIDTH-1:0]};
            2'd1: w_load_data = r_uns
                ? {{(DATA_WIDTH - 2*COL_WIDTH){1'b0}}, w_lane[2*COL_WIDTH-1:0]}
                : {{(DATA_WIDTH - 2*COL_WIDTH){w_lane[2*COL_WIDTH-1]}},
                   w_lane[2*COL_WIDTH-1:0]};
            default: w_load_data = mem_data_i;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM next state and response registers
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next   = r_state;
        w_rdata_next   = r_rdata;
        w_rsp_err_next = r_rsp_err;
        unique case (r_state)
            StIdle: begin
                if (req_valid_i) begin
                    w_state_next = StWait;
                end
            end
            StWait: begin
                w_rdata_next   = (r_err || r_we) ? '0 : w_load_data;
                w_rsp_err_next = r_err;
                w_state_next   = StResp;
            end
            StResp: begin
                if (rsp_ready_i) begin
                    w_rdata_next   = '0;
                    w_rsp_err_next = 1'b0;
                    w_state_next   = StIdle;
                end
            end
            default: begin
                w_rdata_next   = '0;
                w_rsp_err_next = 1'b0;
                w_state_next   = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= StIdle;
            r_we      <= 1'b0;
            r_size    <= 2'd0;
            r_uns     <= 1'b0;
            r_off     <= 2'd0;
            r_err     <= 1'b0;
            r_rdata   <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_rdata   <= w_rdata_next;
            r_rsp_err <= w_rsp_err_next;
            if (w_accept) begin
                r_we   <= req_we_i;
                r_size <= req_size_i;
                r_uns  <= req_unsigned_i;
                r_off  <= req_addr_i[1:0];
                r_err  <= w_err;
            end
        end
    end

    assign req_ready_o = (r_state == StIdle);
    assign rsp_valid_o = (r_state == StResp);
    assign rsp_rdata_o = r_rdata;
    assign rsp_err_o   = r_rsp_err;

endmodule

// File: tb/tb_carp_mem_initiator.sv
module tb_carp_mem_initiator;

    logic        clk;
    logic        rst_ni;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_uns;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_en;
    logic [3:0]  mem_strobe;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    carp_mem_initiator dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_we_i       (req_we),
        .req_size_i     (req_size),
        .req_unsigned_i (req_uns),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .rsp_valid_o    (rsp_valid),
        .rsp_ready_i    (rsp_ready),
        .rsp_rdata_o    (rsp_rdata),
        .rsp_err_o      (rsp_err),
        .mem_en_o       (mem_en),
        .mem_strobe_o   (mem_strobe),
        .mem_addr_o     (mem_addr),
        .mem_data_o     (mem_wdata),
        .mem_data_i     (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-write memory with one-cycle registered read.
    logic [31:0] mem [1024];
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem_rdata = 32'h0;
    end
    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= mem[mem_addr];
            for (int l = 0; l < 4; l++) begin
                if (mem_strobe[l]) mem[mem_addr][8*l +: 8] <= mem_wdata[8*l +: 8];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        en;
        logic [3:0]  strobe;
        logic [9:0]  maddr;
        logic [31:0] mdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic we, logic [1:0] size, logic uns,
                                logic [11:0] addr, logic [31:0] wdata, logic en,
                                logic [3:0] strobe, logic [9:0] maddr, logic [31:0] mdata,
                                logic [31:0] rdata, logic err);
        vec_t v;
        v.name = name; v.we = we; v.size = size; v.uns = uns; v.addr = addr;
        v.wdata = wdata; v.en = en; v.strobe = strobe; v.maddr = maddr;
        v.mdata = mdata; v.rdata = rdata; v.err = err;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_size  = 2'd0;
        req_uns   = 1'b0;
        req_addr  = 12'h0;
        req_wdata = 32'h0;
    endtask

    // Full transaction with rsp_ready held high: accept N, response N+2, idle N+3.
    task automatic run_vec(vec_t v);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = v.we;
        req_size  = v.size;
        req_uns   = v.uns;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        rsp_ready = 1'b1;
        #1;
        check({v.name, " req_ready"}, 32'(req_ready), 32'd1);
        check({v.name, " mem_en"}, 32'(mem_en), 32'(v.en));
        check({v.name, " strobe"}, 32'(mem_strobe), 32'(v.strobe));
        check({v.name, " mem_addr"}, 32'(mem_addr), 32'(v.maddr));
        check({v.name, " mem_data"}, mem_wdata, v.mdata);
        @(negedge clk);
        idle_inputs();
        #1;
        check({v.name, " N+1 rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({v.name, " N+1 mem_en"}, 32'(mem_en), 32'd0);
        @(negedge clk);
        #1;
        check({v.name, " N+2 rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({v.name, " rdata"}, rsp_rdata, v.rdata);
        check({v.name, " err"}, 32'(rsp_err), 32'(v.err));
        check({v.name, " N+2 req_ready"}, 32'(req_ready), 32'd0);
        @(negedge clk);
        #1;
        check({v.name, " N+3 rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({v.name, " N+3 req_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        idle_inputs();
        rsp_ready = 1'b0;
        rst_ni    = 1'b0;
        #1;
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset mem_en", 32'(mem_en), 32'd0);
        check("reset rdata", rsp_rdata, 32'd0);
        check("reset err", 32'(rsp_err), 32'd0);
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;

        //                name           we  sz  u  addr     wdata         en strb maddr  mdata         rdata         err
        vecs.push_back(mk("st_w_010",   1, 2, 0, 12'h010, 32'hDEADBEEF, 1, 4'hF, 10'h4, 32'hDEADBEEF, 32'h0,        0));
        vecs.push_back(mk("ld_w_010",   0, 2, 0, 12'h010, 32'h0,        1, 4'h0, 10'h4, 32'h0,        32'hDEADBEEF, 0));
        vecs.push_back(mk("st_b_013",   1, 0, 0, 12'h013, 32'h12345680, 1, 4'h8, 10'h4, 32'h80808080, 32'h0,        0));
        vecs.push_back(mk("ld_bs_013",  0, 0, 0, 12'h013, 32'h0,        1, 4'h0, 10'h4, 32'h0,        32'hFFFFFF80, 0));
        vecs.push_back(mk("ld_bu_013",  0, 0, 1, 12'h013, 32'h0,        1, 4'h0, 10'h4, 32'h0,        32'h00000080, 0));
        vecs.push_back(mk("st_w_8001",  1, 2, 0, 12'h010, 32'h80011234, 1, 4'hF, 10'h4, 32'h80011234, 32'h0,        0));
        vecs.push_back(mk("ld_hs_012",  0, 1, 0, 12'h012, 32'h0,        1, 4'h0, 10'h4, 32'h0,        32'hFFFF8001, 0));
        vecs.push_back(mk("ld_hu_010",  0, 1, 1, 12'h010, 32'h0,        1, 4'h0, 10'h4, 32'h0,        32'h00001234, 0));
        vecs.push_back(mk("st_h_016",   1, 1, 0, 12'h016, 32'h0000ABCD, 1, 4'hC, 10'h5, 32'hABCDABCD, 32'h0,        0));
        vecs.push_back(mk("ld_hs_016",  0, 1, 0, 12'h016, 32'h0,        1, 4'h0, 10'h5, 32'h0,        32'hFFFFABCD, 0));
        vecs.push_back(mk("ld_bu_011",  0, 0, 1, 12'h011, 32'h0,        1, 4'h0, 10'h4, 32'h0,        32'h00000012, 0));
        vecs.push_back(mk("ld_bs_010",  0, 0, 0, 12'h010, 32'h0,        1, 4'h0, 10'h4, 32'h0,        32'h00000034, 0));
        vecs.push_back(mk("st_b_011",   1, 0, 0, 12'h011, 32'h0000005A, 1, 4'h2, 10'h4, 32'h5A5A5A5A, 32'h0,        0));
        vecs.push_back(mk("ld_w_010b",  0, 2, 0, 12'h010, 32'h0,        1, 4'h0, 10'h4, 32'h0,        32'h80015A34, 0));
        vecs.push_back(mk("err_h_011",  0, 1, 0, 12'h011, 32'h0,        0, 4'h0, 10'h0, 32'h0,        32'h0,        1));
        vecs.push_back(mk("err_w_012",  1, 2, 0, 12'h012, 32'hDEADBEEF, 0, 4'h0, 10'h0, 32'h0,        32'h0,        1));
        vecs.push_back(mk("err_sz3",    0, 3, 0, 12'h010, 32'h0,        0, 4'h0, 10'h0, 32'h0,        32'h0,        1));
        vecs.push_back(mk("ld_w_after", 0, 2, 0, 12'h010, 32'h0,        1, 4'h0, 10'h4, 32'h0,        32'h80015A34, 0));

        foreach (vecs[i]) run_vec(vecs[i]);

        // Back-pressure: word load of 0x014 (word 5 = 0xABCD0000), ready low 5 cycles.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_uns = 1'b0;
        req_addr = 12'h014; req_wdata = 32'h0; rsp_ready = 1'b0;
        #1;
        check("bp accept mem_en", 32'(mem_en), 32'd1);
        @(negedge clk);
        // Stray store request outside idle must be ignored.
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 12'h020;
        req_wdata = 32'hFFFFFFFF;
        #1;
        check("bp stray mem_en N+1", 32'(mem_en), 32'd0);
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp rdata", rsp_rdata, 32'hABCD0000);
            check("bp err", 32'(rsp_err), 32'd0);
            check("bp req_ready", 32'(req_ready), 32'd0);
            check("bp mem_en", 32'(mem_en), 32'd0);
            @(negedge clk);
        end
        idle_inputs();
        rsp_ready = 1'b1;
        #1;
        check("bp release req_ready same cycle", 32'(req_ready), 32'd0);
        check("bp release rsp_valid", 32'(rsp_valid), 32'd1);
        @(negedge clk);
        #1;
        check("bp after req_ready", 32'(req_ready), 32'd1);
        check("bp after rsp_valid", 32'(rsp_valid), 32'd0);
        run_vec(mk("ld_w_020_untouched", 0, 2, 0, 12'h020, 32'h0, 1, 4'h0, 10'h8, 32'h0,
                   32'h0, 0));

        // Reset while waiting on a store: store sticks, response is dropped.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_uns = 1'b0;
        req_addr = 12'h020; req_wdata = 32'h11223344; rsp_ready = 1'b1;
        #1;
        check("rst store mem_en", 32'(mem_en), 32'd1);
        @(negedge clk);
        idle_inputs();
        #1;
        check("rst in wait req_ready", 32'(req_ready), 32'd0);
        rst_ni = 1'b0;
        #1;
        check("rst async rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst async req_ready", 32'(req_ready), 32'd1);
        check("rst async rdata", rsp_rdata, 32'd0);
        check("rst async err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("rst no late rsp_valid", 32'(rsp_valid), 32'd0);
            @(negedge clk);
        end
        run_vec(mk("ld_w_020_post_rst", 0, 2, 0, 12'h020, 32'h0, 1, 4'h0, 10'h8, 32'h0,
                   32'h11223344, 0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
